// File: rtl/mem_arbiter_if.sv
// Core-side request/response lines and shared data-RAM bus of mem_arbiter.
// The arbiter takes the slave view; the cores plus the RAM take the master view.
interface mem_arbiter_if #(
    parameter int NUM_CORES = 4,
    parameter int ID_W      = 2,
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8
);
    logic [NUM_CORES-1:0][1:0]        core_mem_ctrl;
    logic [NUM_CORES-1:0][ADDR_W-1:0] core_addr;
    logic [NUM_CORES-1:0][DATA_W-1:0] core_wdata;
    logic [NUM_CORES-1:0]             core_done;
    logic [DATA_W-1:0]                rdata;
    logic [ID_W-1:0]                  grant_id;
    logic                             busy;
    logic [ADDR_W-1:0]                mem_addr;
    logic [DATA_W-1:0]                mem_wdata;
    logic                             mem_we;
    logic                             mem_re;
    logic [DATA_W-1:0]                mem_rdata;

    modport slave (
        input  core_mem_ctrl, core_addr, core_wdata, mem_rdata,
        output core_done, rdata, grant_id, busy, mem_addr, mem_wdata, mem_we, mem_re
    );

    modport master (
        output core_mem_ctrl, core_addr, core_wdata, mem_rdata,
        input  core_done, rdata, grant_id, busy, mem_addr, mem_wdata, mem_we, mem_re
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port data RAM between NUM_CORES cores,
// one access in flight; latches the winner's request and sequences the RAM.
module mem_arbiter #(
    parameter int NUM_CORES = 4,
    parameter int ID_W      = 2,
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int MEM_LAT   = 1
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);
    localparam int CNT_W = $clog2(MEM_LAT + 1);
    // WAIT spans MEM_LAT-1 cycles: load N-2 and leave when the counter hits zero.
    localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'((MEM_LAT > 1) ? MEM_LAT - 2 : 0);
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b10;

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_CAPTURE, S_DONE} state_e;

    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    state_e            state_q, state_d;
    req_t              req_q, req_d;
    logic [ID_W-1:0]   grant_q, grant_d;
    logic [ID_W-1:0]   last_q, last_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [NUM_CORES-1:0] req_vec;
    logic                 pick_vld;
    logic [ID_W-1:0]      pick_id;
    logic [ID_W-1:0]      scan_id;

    for (genvar i = 0; i < NUM_CORES; i++) begin : g_req
        assign req_vec[i] = (bus.core_mem_ctrl[i] == OP_READ) ||
                            (bus.core_mem_ctrl[i] == OP_WRITE);
    end

    // Scan farthest-to-nearest from last+1 so the nearest requester overwrites.
    always_comb begin
        pick_vld = 1'b0;
        pick_id  = '0;
        scan_id  = '0;
        for (int k = NUM_CORES; k >= 1; k--) begin
            scan_id = ID_W'((int'(last_q) + k) % NUM_CORES);
            if (req_vec[scan_id]) begin
                pick_vld = 1'b1;
                pick_id  = scan_id;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        grant_d = grant_q;
        last_d  = last_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (pick_vld) begin
                    grant_d     = pick_id;
                    last_d      = pick_id;
                    req_d.wr    = (bus.core_mem_ctrl[pick_id] == OP_WRITE);
                    req_d.addr  = bus.core_addr[pick_id];
                    req_d.wdata = bus.core_wdata[pick_id];
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (req_q.wr) begin
                    state_d = S_DONE;
                end else if (MEM_LAT > 1) begin
                    state_d = S_WAIT;
                    cnt_d   = WAIT_INIT;
                end else begin
                    state_d = S_CAPTURE;
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) state_d = S_CAPTURE;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            S_CAPTURE: begin
                rdata_d = bus.mem_rdata;
                state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            req_q   <= '0;
            grant_q <= '0;
            last_q  <= ID_W'(NUM_CORES - 1);
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.busy      = (state_q != S_IDLE);
    assign bus.mem_we    = (state_q == S_ISSUE) && req_q.wr;
    assign bus.mem_re    = (state_q == S_ISSUE) && !req_q.wr;
    assign bus.mem_addr  = req_q.addr;
    assign bus.mem_wdata = req_q.wdata;
    assign bus.core_done = (state_q == S_DONE) ? (NUM_CORES'(1) << grant_q) : '0;
    assign bus.grant_id  = grant_q;
    assign bus.rdata     = rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level reference model checked every cycle
// against a MEM_LAT=1 instance, plus directed reset-in-WAIT run on a MEM_LAT=3 instance.
module tb_mem_arbiter;
    localparam int NC = 4;
    localparam int IDW = 2;
    localparam int AW = 8;
    localparam int DW = 8;
    localparam int LAT1 = 1;

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic rst3 = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if #(.NUM_CORES(NC), .ID_W(IDW), .ADDR_W(AW), .DATA_W(DW)) bus1 ();
    mem_arbiter_if #(.NUM_CORES(NC), .ID_W(IDW), .ADDR_W(AW), .DATA_W(DW)) bus3 ();

    mem_arbiter #(.NUM_CORES(NC), .ID_W(IDW), .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT1))
        u_dut (.clk(clk), .rst(rst), .bus(bus1.slave));
    mem_arbiter #(.NUM_CORES(NC), .ID_W(IDW), .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(3))
        u_dut3 (.clk(clk), .rst(rst3), .bus(bus3.slave));

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] pat(input int a);
        return 8'(a * 7 + 3);
    endfunction

    // RAM behind DUT1 (1-cycle read) and a fixed-pattern 3-stage RAM behind DUT3
    logic [DW-1:0] mem1 [256];
    logic [DW-1:0] rd1;
    logic          mem_init = 1'b0;
    logic [DW-1:0] p3 [3];
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int a = 0; a < 256; a++) mem1[a] <= pat(a);
            mem_init <= 1'b1;
        end else begin
            if (bus1.mem_we) mem1[bus1.mem_addr] <= bus1.mem_wdata;
            if (bus1.mem_re) rd1 <= mem1[bus1.mem_addr];
        end
        if (bus3.mem_re) p3[0] <= bus3.mem_addr ^ 8'h3C;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign bus1.mem_rdata = rd1;
    assign bus3.mem_rdata = p3[2];

    // Reference model: an access granted at cycle t strobes at t+1 and completes at t+2 (+LAT for reads)
    logic [DW-1:0] ref_mem [256];
    bit            ref_init = 0;
    bit            model_en = 0;
    int            cyc = 0;
    bit            m_act = 0;
    int            m_start, m_end, m_id;
    bit            m_wr;
    logic [7:0]    m_addr, m_wdata, m_rdval;
    logic [7:0]    m_rdata = '0;
    int            m_last = NC - 1;
    int            m_grant = 0;
    logic [NC-1:0] done_seen = '0;
    int            order_q[$];
    bit            junk_win = 0;
    int            junk_hits = 0;

    always @(negedge clk) begin
        logic [NC-1:0] exp_done;
        bit exp_we, exp_re, found;
        int win, idx;
        cyc++;
        done_seen = bus1.core_done;
        if (!ref_init) begin
            for (int a = 0; a < 256; a++) ref_mem[a] = pat(a);
            ref_init = 1;
        end
        if (junk_win && (bus1.mem_we || bus1.mem_re) && bus1.mem_addr == 8'h77) junk_hits++;
        if (model_en) begin
            if (m_act && cyc > m_end) m_act = 0;
            exp_done = '0; exp_we = 0; exp_re = 0;
            if (m_act) begin
                if (cyc == m_start + 1) begin exp_we = m_wr; exp_re = !m_wr; end
                if (cyc == m_end) begin
                    exp_done = 4'(1) << m_id;
                    if (!m_wr) m_rdata = m_rdval;
                end
            end
            chk("busy", bus1.busy, m_act);
            chk("core_done", bus1.core_done, exp_done);
            chk("mem_we", bus1.mem_we, exp_we);
            chk("mem_re", bus1.mem_re, exp_re);
            if (exp_we || exp_re) chk("mem_addr", bus1.mem_addr, m_addr);
            if (exp_we) chk("mem_wdata", bus1.mem_wdata, m_wdata);
            chk("grant_id", bus1.grant_id, m_grant);
            chk("rdata", bus1.rdata, m_rdata);
            if (exp_done != '0) order_q.push_back(m_id);
            if (rst) begin
                m_act = 0; m_last = NC - 1; m_grant = 0; m_rdata = '0;
            end else if (!m_act) begin
                found = 0; win = 0;
                for (int k = 1; k <= NC; k++) begin
                    idx = (m_last + k) % NC;
                    if (!found && (bus1.core_mem_ctrl[idx] == 2'b01 || bus1.core_mem_ctrl[idx] == 2'b10)) begin
                        found = 1; win = idx;
                    end
                end
                if (found) begin
                    m_act = 1; m_start = cyc; m_id = win;
                    m_wr = (bus1.core_mem_ctrl[win] == 2'b10);
                    m_addr = bus1.core_addr[win]; m_wdata = bus1.core_wdata[win];
                    m_end = cyc + 2 + (m_wr ? 0 : LAT1);
                    m_last = win; m_grant = win;
                    if (m_wr) ref_mem[m_addr] = m_wdata;
                    else      m_rdval = ref_mem[m_addr];
                end
            end
        end
    end

    // Core agents: hold a request until its done is seen, then drop it the next cycle
    bit         req_on [NC];
    logic [1:0] d_op   [NC];
    logic [7:0] d_addr [NC];
    logic [7:0] d_wdata[NC];
    int         cool   [NC];
    bit         d_junk [NC];

    task automatic step(input bit auto_new);
        @(posedge clk); #1;
        for (int i = 0; i < NC; i++) begin
            if (req_on[i]) begin
                if (done_seen[i]) begin
                    req_on[i] = 0;
                    cool[i]   = $urandom_range(0, 3);
                    d_junk[i] = auto_new && ($urandom_range(0, 3) == 0);
                end else if (m_act && m_id == i) begin
                    d_addr[i]  = 8'($urandom);
                    d_wdata[i] = 8'($urandom);
                end
            end else if (cool[i] != 0) begin
                cool[i]--;
            end else if (auto_new && $urandom_range(0, 1) == 1) begin
                req_on[i]  = 1;
                d_op[i]    = 2'($urandom_range(1, 2));
                d_addr[i]  = 8'($urandom);
                d_wdata[i] = 8'($urandom);
            end
            bus1.core_mem_ctrl[i] = req_on[i] ? d_op[i] : (d_junk[i] ? 2'b11 : 2'b00);
            bus1.core_addr[i]     = d_addr[i];
            bus1.core_wdata[i]    = d_wdata[i];
        end
    endtask

    task automatic set_req(input int i, input logic [1:0] op, input logic [7:0] a, input logic [7:0] d);
        req_on[i] = 1; d_op[i] = op; d_addr[i] = a; d_wdata[i] = d; cool[i] = 0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        bit pend;
        n = 0;
        do begin
            step(0);
            n++;
            pend = bus1.busy;
            for (int i = 0; i < NC; i++) pend |= req_on[i];
        end while (pend && n < 80);
        chk({tag, "_drain"}, pend, 0);
    endtask

    task automatic do_reset();
        for (int i = 0; i < NC; i++) req_on[i] = 0;
        rst = 1;
        step(0);
        step(0);
        rst = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NC; i++) begin
            req_on[i] = 0; d_op[i] = 2'b00; d_addr[i] = '0; d_wdata[i] = '0; cool[i] = 0; d_junk[i] = 0;
            bus3.core_mem_ctrl[i] = 2'b00; bus3.core_addr[i] = '0; bus3.core_wdata[i] = '0;
        end
        bus1.core_mem_ctrl = '0; bus1.core_addr = '0; bus1.core_wdata = '0;

        step(0);
        model_en = 1;
        step(0);
        rst = 0;
        chk("rst_busy", bus1.busy, 0);
        chk("rst_grant", bus1.grant_id, 0);

        // core2 WRITE 0x10 <= 0xA5
        set_req(2, 2'b10, 8'h10, 8'hA5);
        step(0); @(negedge clk); chk("t1_busy_t", bus1.busy, 0);
        step(0); @(negedge clk);
        chk("t1_we", bus1.mem_we, 1); chk("t1_addr", bus1.mem_addr, 8'h10); chk("t1_wdata", bus1.mem_wdata, 8'hA5);
        step(0); @(negedge clk);
        chk("t1_done", bus1.core_done, 4'b0100); chk("t1_grant", bus1.grant_id, 2);
        chk("t1_busy_done", bus1.busy, 1); chk("t1_we_off", bus1.mem_we, 0);
        step(0); @(negedge clk); chk("t1_busy_after", bus1.busy, 0);

        // last=2, cores 1 and 3 READ together: 3 then 1
        order_q.delete();
        set_req(1, 2'b01, 8'h10, 8'h00);
        set_req(3, 2'b01, 8'h30, 8'h00);
        wait_idle("t4");
        chk("t4_count", order_q.size(), 2);
        if (order_q.size() == 2) begin
            chk("t4_first", order_q[0], 3);
            chk("t4_second", order_q[1], 1);
        end
        chk("t4_rdata", bus1.rdata, 8'hA5);

        // core1 READ 0x10 alone, MEM_LAT=1 timing
        set_req(1, 2'b01, 8'h10, 8'h00);
        step(0); @(negedge clk);
        step(0); @(negedge clk);
        chk("t2_re", bus1.mem_re, 1); chk("t2_we", bus1.mem_we, 0); chk("t2_addr", bus1.mem_addr, 8'h10);
        step(0); @(negedge clk);
        chk("t2_re_off", bus1.mem_re, 0); chk("t2_nodone", bus1.core_done, 0);
        step(0); @(negedge clk);
        chk("t2_done", bus1.core_done, 4'b0010); chk("t2_rdata", bus1.rdata, 8'hA5);
        wait_idle("t2");
        chk("t2_rdata_hold", bus1.rdata, 8'hA5);

        // all four WRITE after reset: grants 0,1,2,3
        do_reset();
        order_q.delete();
        for (int i = 0; i < NC; i++) set_req(i, 2'b10, 8'(8'h20 + i), 8'(8'h50 + i));
        wait_idle("t3");
        chk("t3_count", order_q.size(), 4);
        if (order_q.size() == 4)
            for (int i = 0; i < NC; i++) chk("t3_order", order_q[i], i);
        for (int i = 0; i < NC; i++) chk("t3_mem", mem1[8'h20 + i], 8'(8'h50 + i));

        // core0 ctrl=11 is not a request
        d_junk[0] = 1; d_addr[0] = 8'h77; junk_win = 1; junk_hits = 0;
        order_q.delete();
        set_req(1, 2'b01, 8'h05, 8'h00);
        wait_idle("t6");
        for (int i = 0; i < 5; i++) step(0);
        chk("t6_count", order_q.size(), 1);
        if (order_q.size() == 1) chk("t6_who", order_q[0], 1);
        chk("t6_junk_strobes", junk_hits, 0);
        chk("t6_rdata", bus1.rdata, pat(5));
        d_junk[0] = 0; junk_win = 0;

        // randomized contention with occasional mid-access resets
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 399) == 0);
            step(1);
        end
        rst = 0;
        wait_idle("rand");

        // MEM_LAT=3 instance: reset during WAIT, then cores 0 and 3
        @(posedge clk); #1; rst3 = 0;
        @(negedge clk);
        chk("l3_rst_busy", bus3.busy, 0); chk("l3_rst_rdata", bus3.rdata, 0); chk("l3_rst_grant", bus3.grant_id, 0);
        @(posedge clk); #1; bus3.core_mem_ctrl[0] = 2'b01; bus3.core_addr[0] = 8'h40;
        @(posedge clk); #1;
        @(negedge clk); chk("l3_issue_re", bus3.mem_re, 1);
        @(posedge clk); #1; rst3 = 1;
        @(negedge clk); chk("l3_wait_busy", bus3.busy, 1); chk("l3_wait_re", bus3.mem_re, 0);
        @(posedge clk); #1; rst3 = 0;
        bus3.core_mem_ctrl[3] = 2'b01; bus3.core_addr[3] = 8'h41;
        @(negedge clk);
        chk("l3_after_busy", bus3.busy, 0); chk("l3_after_re", bus3.mem_re, 0); chk("l3_after_done", bus3.core_done, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("l3_grant0", bus3.grant_id, 0); chk("l3_re0", bus3.mem_re, 1); chk("l3_addr0", bus3.mem_addr, 8'h40);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            @(negedge clk); chk("l3_nodone", bus3.core_done, 0);
        end
        @(posedge clk); #1;
        @(negedge clk);
        chk("l3_done0", bus3.core_done, 4'b0001); chk("l3_rdata0", bus3.rdata, 8'h7C);
        @(posedge clk); #1; bus3.core_mem_ctrl[0] = 2'b00;
        begin
            int waited;
            waited = 0;
            do begin
                @(negedge clk);
                waited++;
                if (bus3.core_done[3]) break;
                @(posedge clk); #1;
            end while (waited < 12);
            chk("l3_lat3", waited, 6);
            chk("l3_done3", bus3.core_done, 4'b1000);
            chk("l3_grant3", bus3.grant_id, 3);
            chk("l3_rdata3", bus3.rdata, 8'h7D);
        end
        @(posedge clk); #1; bus3.core_mem_ctrl[3] = 2'b00;
        @(negedge clk); chk("l3_idle", bus3.core_done, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
